// File: rtl/pn_pkg.sv
// Shared constants for the pn15_gen PN generator bank.
// Widths, second taps and the all-ones seed.
package pn_pkg;

  localparam int PN15_W   = 4;
  localparam int PN31_W   = 5;
  localparam int PN511_W  = 9;
  localparam int PN1023_W = 10;
  localparam int PN2047_W = 11;

  localparam int PN15_K   = 3;
  localparam int PN31_K   = 3;
  localparam int PN511_K  = 5;
  localparam int PN1023_K = 7;
  localparam int PN2047_K = 9;

  localparam logic [15:0] PN_SEED = 16'hFFFF;

endpackage

// File: rtl/pn_lfsr_fib.sv
// One Fibonacci LFSR, polynomial x^N + x^K + 1, seeded all-ones.
// Macro PN_LOCKUP_GUARD_EN: reload the seed from the all-zero state.
module pn_lfsr_fib
  import pn_pkg::*;
#(
  parameter int N = 4,
  parameter int K = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic valid,
  output logic out
);

  localparam logic [N-1:0] SEED = PN_SEED[N-1:0];

  logic [N-1:0] s;
  logic [N-1:0] nxt;

  // next state: shift left, feedback from the two taps into bit 0
  always_comb begin
    nxt = {s[N-2:0], s[N-1] ^ s[K-1]};
`ifdef PN_LOCKUP_GUARD_EN
    if (s == '0) nxt = SEED;
`endif
  end

  // state register; reset input is active-high despite its name
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n)    s <= SEED;
    else if (valid) s <= nxt;
  end

  assign out = s[N-1];

endmodule

// File: rtl/pn15_gen.sv
// Bank of five maximal-length PN generators sharing one advance enable.
// Macro PN_LOCKUP_GUARD_EN enables all-zero lockup recovery.
module pn15_gen
  import pn_pkg::*;
#(
  parameter bit OUT_INV = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic valid,
  output logic PN15,
  output logic PN31,
  output logic PN511,
  output logic PN1023,
  output logic PN2047
);

  logic [4:0] raw;

  pn_lfsr_fib #(.N(PN15_W), .K(PN15_K)) u_pn15 (
    .clk     (clk),
    .reset_n (reset_n),
    .valid   (valid),
    .out     (raw[0])
  );

  pn_lfsr_fib #(.N(PN31_W), .K(PN31_K)) u_pn31 (
    .clk     (clk),
    .reset_n (reset_n),
    .valid   (valid),
    .out     (raw[1])
  );

  pn_lfsr_fib #(.N(PN511_W), .K(PN511_K)) u_pn511 (
    .clk     (clk),
    .reset_n (reset_n),
    .valid   (valid),
    .out     (raw[2])
  );

  pn_lfsr_fib #(.N(PN1023_W), .K(PN1023_K)) u_pn1023 (
    .clk     (clk),
    .reset_n (reset_n),
    .valid   (valid),
    .out     (raw[3])
  );

  pn_lfsr_fib #(.N(PN2047_W), .K(PN2047_K)) u_pn2047 (
    .clk     (clk),
    .reset_n (reset_n),
    .valid   (valid),
    .out     (raw[4])
  );

  assign PN15   = raw[0] ^ OUT_INV;
  assign PN31   = raw[1] ^ OUT_INV;
  assign PN511  = raw[2] ^ OUT_INV;
  assign PN1023 = raw[3] ^ OUT_INV;
  assign PN2047 = raw[4] ^ OUT_INV;

endmodule

// File: tb/tb_pn15_gen.sv
// Self-checking bench for pn15_gen: sequence-level model, every-cycle compare.
// Covers reset, continuous/strobed/random advance, async reset, lockup, OUT_INV.
module tb_pn15_gen;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       valid = 1'b0;
  logic [4:0] po;
  logic [4:0] pv;
  logic       chk_en = 1'b0;

  int checks = 0;
  int failures = 0;

  int nw [5] = '{4, 5, 9, 10, 11};
  int kt [5] = '{3, 3, 5, 7, 9};
  int per [5];
  bit seq [5][4096];
  int idx = 0;

  always #5 clk = ~clk;

  pn15_gen #(.OUT_INV(1'b0)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .valid   (valid),
    .PN15    (po[0]),
    .PN31    (po[1]),
    .PN511   (po[2]),
    .PN1023  (po[3]),
    .PN2047  (po[4])
  );

  pn15_gen #(.OUT_INV(1'b1)) dut_inv (
    .clk     (clk),
    .reset_n (reset_n),
    .valid   (valid),
    .PN15    (pv[0]),
    .PN31    (pv[1]),
    .PN511   (pv[2]),
    .PN1023  (pv[3]),
    .PN2047  (pv[4])
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // step count since reset; the output is the m-sequence at that position
  always @(posedge clk or posedge reset_n) begin
    if (reset_n)    idx <= 0;
    else if (valid) idx <= idx + 1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int g = 0; g < 5; g++) begin
        chk($sformatf("pn%0d", g), int'(po[g]), int'(seq[g][idx % per[g]]));
        chk($sformatf("inv%0d", g), int'(pv[g]), int'(!seq[g][idx % per[g]]));
      end
    end
  end

  task automatic run(input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      case (mode)
        0: valid = 1'b1;
        1: valid = (i % 8) == 7;
        default: valid = 1'($urandom_range(0, 1));
      endcase
    end
  endtask

  initial begin
    int ones;
    bit exp15 [15] = '{1,1,1,1,0,0,0,1,0,0,1,1,0,1,0};

    // model: o[t] = o[t-N] ^ o[t-K], first N outputs are ones
    for (int g = 0; g < 5; g++) begin
      per[g] = (1 << nw[g]) - 1;
      for (int t = 0; t < nw[g]; t++) seq[g][t] = 1'b1;
      for (int t = nw[g]; t < per[g] + nw[g]; t++)
        seq[g][t] = seq[g][t - nw[g]] ^ seq[g][t - kt[g]];
    end

    for (int t = 0; t < 15; t++)
      chk($sformatf("model15_%0d", t), int'(seq[0][t]), int'(exp15[t]));
    for (int g = 0; g < 5; g++) begin
      ones = 0;
      for (int t = 0; t < per[g]; t++) ones += int'(seq[g][t]);
      chk($sformatf("model_ones%0d", g), ones, 1 << (nw[g] - 1));
      for (int t = 0; t < nw[g]; t++)
        chk($sformatf("model_wrap%0d", g), int'(seq[g][per[g] + t]), 1);
    end

    #1 reset_n = 1'b1;
    #2;
    chk("rst_pn15", int'(po[0]), 1);
    chk("rst_inv15", int'(pv[0]), 0);
    chk("rst_all", int'(po), 31);
    chk("rst_all_inv", int'(pv), 0);

    // reset wins over valid on the same edges
    valid = 1'b1;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(posedge clk);
    #1 reset_n = 1'b0;

    run(40, 0);
    run(2060, 0);
    run(800, 1);
    run(600, 2);

    // async reset mid-sequence, between edges
    @(posedge clk);
    #1 reset_n = 1'b1;
    valid = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b0;
    run(7, 0);
    @(posedge clk);
    #2 reset_n = 1'b1;
    #1;
    chk("async_rst", int'(po), 31);
    chk("async_rst_inv", int'(pv), 0);
    @(posedge clk);
    #1 reset_n = 1'b0;
    run(30, 0);

    // lockup: force PN31 register to zero
    @(posedge clk);
    #1 valid = 1'b0;
    chk_en = 1'b0;
    @(negedge clk);
    force dut.u_pn31.s = '0;
    #1 release dut.u_pn31.s;
    #1 chk("lock_out", int'(po[1]), 0);
    for (int j = 0; j < 4; j++) begin
      @(posedge clk);
      #1 valid = 1'b1;
      @(posedge clk);
      #1 valid = 1'b0;
`ifdef PN_LOCKUP_GUARD_EN
      chk($sformatf("lock_step%0d", j), int'(po[1]), int'(seq[1][j]));
`else
      chk($sformatf("lock_step%0d", j), int'(po[1]), 0);
`endif
    end

    @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1 reset_n = 1'b0;
    chk_en = 1'b1;
    run(50, 2);

    @(posedge clk);
    #1 chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pn15_gen.md
Name: pn15_gen

Overview:
- Bank of five free-standing maximal-length Fibonacci LFSR pseudo-noise generators: periods 15, 31, 511, 1023 and 2047.
- All five share one clock and one advance-enable.
- Feeds the line-code test-data source (jd_gen): its PN15 output becomes jd_data / differential jd_xd once per derived bit period.

Parameters:
- OUT_INV, 0: when 1, every PN output is inverted; LFSR state is unaffected.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  asynchronous reset, ACTIVE-HIGH despite the name (1 = reset asserted); release is sampled by clk.
- valid  input  1  advance enable; every LFSR steps one position on each clk edge where valid=1.
- PN15  output  1  m-sequence, 4-bit LFSR, x^4+x^3+1, period 15.
- PN31  output  1  m-sequence, 5-bit LFSR, x^5+x^3+1, period 31.
- PN511  output  1  m-sequence, 9-bit LFSR, x^9+x^5+1, period 511.
- PN1023  output  1  m-sequence, 10-bit LFSR, x^10+x^7+1, period 1023.
- PN2047  output  1  m-sequence, 11-bit LFSR, x^11+x^9+1, period 2047.

Behaviour:
- Each generator is an N-bit register s[N-1:0] for polynomial x^N+x^k+1.
- Feedback: fb = s[N-1] ^ s[k-1]. Next state: {s[N-2:0], fb}.
- Output: s[N-1], XOR OUT_INV. Combinational from the register, so it is valid in the same cycle the state is updated.
- Reset (reset_n=1): all registers go to all-ones immediately, asynchronously. Outputs therefore read 1 (0 if OUT_INV=1) during and right after reset.
- valid=0: all registers hold.
- valid=1 on a clock edge: all five registers step together. One step = one output bit; there is no extra latency.
- valid held high continuously: new bit every cycle. Valid pulses (e.g. 1 in 8 cycles): one bit per pulse.
- PN15 sequence from reset, one value per step, starting with the value present at reset: 1,1,1,1,0,0,0,1,0,0,1,1,0,1,0, then repeats.
- Every sequence contains 2^(N-1) ones and 2^(N-1)-1 zeros per period. The all-zero state never occurs in normal operation.
- Wrap-around: after exactly 2^N-1 valid steps each register returns to all-ones.
- Reset asserted mid-sequence: immediate return to all-ones. The first valid edge after release produces step 2 of the sequence.
- reset_n and valid both high on an edge: reset wins.

Optional Feature:
- Macro PN_LOCKUP_GUARD_EN.
- Defined: each generator detects an all-zero register (e.g. after a single-event upset). On the next valid edge that register loads all-ones instead of shifting. Output stays 0 while locked.
- Not defined: no detection. An all-zero register stays stuck at 0 forever. The guard logic is not compiled in.

Decomposition:
- Shared package pn_pkg holds:
  - width constants: PN15_W=4, PN31_W=5, PN511_W=9, PN1023_W=10, PN2047_W=11;
  - matching second-tap constants: 3, 3, 5, 7, 9;
  - the seed constant (all-ones).
- One natural sub-module, pn_lfsr_fib, parameterised by width N and tap k, with ports clk, reset_n, valid, out. Instantiated five times by pn15_gen.

Test Plan:
- Reset then valid=1 every cycle -> PN15 shows 1,1,1,1,0,0,0,1,0,0,1,1,0,1,0 and repeats at step 16.
- valid=1 for 2047 cycles -> each output is periodic with period 15/31/511/1023/2047. Ones per period = 8/16/256/512/1024. Each register is all-ones again after its period.
- valid=1 only 1 cycle in 8 (jd_gen-style strobe) -> outputs change only on strobe edges. Same bit sequence as the continuous case.
- Assert reset_n=1 asynchronously after 7 steps, between clock edges -> all outputs return to 1 immediately. Sequence restarts from step 1 after release. Reset with valid=1 on the same edge -> reset wins.
- With PN_LOCKUP_GUARD_EN: force the PN31 register to 0 -> the next valid edge reloads 11111 and the sequence resumes from step 1. Without the macro: the output stays 0.
- OUT_INV=1 -> the PN15 stream is the bitwise inverse of the first scenario: 0,0,0,0,1,1,1,0,...
